rd_adder_seq: RTL and testbench

- Multi-cycle WIDTH-bit adder/subtractor built on the team's recursive-doubling KPG carry scheme.
- The block is the producing end of the KPG interface. It encodes operands into per-bit kill/propagate/generate codes, resolves them with one doubling level per clock, then consumes the resolved carries to form sum, carry-out and overflow.
- Sits in the Experiment 1 datapath as the sequential, handshaked arithmetic unit.

---
 rtl/rd_adder_seq_if.sv | 27 ++
 rtl/rd_adder_seq.sv | 139 +++++++++++++
 tb/tb_rd_adder_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rd_adder_seq_if.sv
// rd_adder_seq_if: operand/result handshake bundle for rd_adder_seq.
//   master: drives in_valid, a, b, cin, sub, out_ready; samples in_ready,
//           out_valid, sum, cout, overflow.
//   slave : the adder side (opposite directions).
interface rd_adder_seq_if #(parameter int WIDTH = 24);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/rd_adder_seq.sv
// rd_adder_seq: multi-cycle WIDTH-bit adder/subtractor using recursive-doubling
// KPG carry resolution, one doubling level per clock.
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   bus       rd_adder_seq_if.slave
//     in_valid/in_ready   operand handshake (a, b, cin, sub)
//     out_valid/out_ready result handshake (sum, cout, overflow)
// Result appears LEVELS+2 edges after the accepting edge, independent of data.
module rd_adder_seq #(
  parameter int WIDTH  = 24,
  parameter int LEVELS = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  rd_adder_seq_if.slave bus
);

  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS + 1) : 1;

  typedef enum logic [2:0] {IDLE, ENCODE, RESOLVE, SUM, HOLD} state_t;
  typedef logic [1:0] kpg_t;

  localparam kpg_t KILL = 2'b00;
  localparam kpg_t PROP = 2'b01;
  localparam kpg_t GEN  = 2'b11;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bp_q;     // effective operand b' (inverted for subtract)
  logic             cin_q;    // effective carry-in
  kpg_t [WIDTH:0]   code;     // code[0] is the carry-in, code[i+1] is bit i
  kpg_t [WIDTH:0]   code_enc;
  kpg_t [WIDTH:0]   code_res;
  logic [LW-1:0]    lvl;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_nxt;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;

  // Per-bit encode: {a&b', a|b'} yields 11/01/00 and never 10.
  always_comb begin
    code_enc    = '0;
    code_enc[0] = cin_q ? GEN : KILL;
    for (int i = 0; i < WIDTH; i++)
      code_enc[i+1] = {a_q[i] & bp_q[i], a_q[i] | bp_q[i]};
  end

  // One doubling level: a propagate position inherits the code d=2^lvl below
  // it. All positions read the previous vector, so updates are simultaneous.
  always_comb begin
    code_res = code;
    for (int l = 0; l < LEVELS; l++) begin
      if (lvl == LW'(l)) begin
        for (int j = (1 << l); j <= WIDTH; j++) begin
          if (code[j] == PROP)
            code_res[j] = code[j - (1 << l)];
        end
      end
    end
  end

  // Once resolved, bit 1 of each code is the carry into that position.
  always_comb begin
    carry = '0;
    for (int i = 0; i < WIDTH; i++)
      carry[i] = code[i][1];
    sum_nxt = a_q ^ bp_q ^ carry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      bp_q        <= '0;
      cin_q       <= 1'b0;
      code        <= '0;
      lvl         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            bp_q       <= bus.sub ? ~bus.b : bus.b;
            cin_q      <= bus.sub | bus.cin;
            in_ready_q <= 1'b0;
            state      <= ENCODE;
          end
        end
        ENCODE: begin
          code  <= code_enc;
          lvl   <= '0;
          state <= RESOLVE;
        end
        RESOLVE: begin
          code <= code_res;
          lvl  <= lvl + 1'b1;
          if (lvl == LW'(LEVELS - 1))
            state <= SUM;
        end
        SUM: begin
          sum_q       <= sum_nxt;
          cout_q      <= code[WIDTH][1];
          ovf_q       <= code[WIDTH-1][1] ^ code[WIDTH][1];
          out_valid_q <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          // Result stays stable until the consumer takes it.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_adder_seq.sv
// tb_rd_adder_seq: directed table, multi-cycle corner sequences and random
// vectors for rd_adder_seq, checked through a result scoreboard.
module tb_rd_adder_seq;
  localparam int W = 24;
  localparam int L = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rd_adder_seq_if #(.WIDTH(W)) bus();
  rd_adder_seq #(.WIDTH(W), .LEVELS(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef logic [W+1:0] res_t;  // {sum, cout, overflow}
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  res_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t tbl[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W-1:0] bp;
    logic [W:0]   full;
    logic         ov;
    bp   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, (sub | cin)};
    ov   = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
    return {full[W-1:0], full[W], ov};
  endfunction

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input res_t exp, input bit push);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin step(); n++; end
    if (bus.in_ready !== 1'b1) begin timeout("accept_wait"); return; end
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    step();
    bus.in_valid = 1'b0;
    if (push) sb.push_back(exp);
    check("busy_in_ready", bus.in_ready, 0);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin step(); n++; end
  endtask

  task automatic collect(input string tag, input int max_stall);
    int   n;
    res_t exp;
    wait_valid(n);
    if (bus.out_valid !== 1'b1) begin timeout({tag, "_out_valid"}); return; end
    check({tag, "_latency"}, n, L + 2);
    repeat ($urandom_range(0, max_stall)) step();
    bus.out_ready = 1'b1;
    if (sb.size() == 0) begin
      timeout({tag, "_scoreboard_empty"});
    end else begin
      exp = sb.pop_front();
      check({tag, "_result"}, {bus.sum, bus.cout, bus.overflow}, exp);
    end
    step();
    bus.out_ready = 1'b0;
    check({tag, "_release"}, bus.out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   seen;
    res_t exp;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    tbl[0] = '{24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0};
    tbl[1] = '{24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1};
    tbl[2] = '{24'h000005, 24'h000007, 1'b0, 1'b1, 24'hFFFFFE, 1'b0, 1'b0};
    tbl[3] = '{24'h000005, 24'h000007, 1'b1, 1'b1, 24'hFFFFFE, 1'b0, 1'b0};
    tbl[4] = '{24'h000000, 24'h000000, 1'b1, 1'b0, 24'h000001, 1'b0, 1'b0};
    tbl[5] = '{24'h800000, 24'h800000, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1};
    tbl[6] = '{24'h800000, 24'h000001, 1'b0, 1'b1, 24'h7FFFFF, 1'b1, 1'b1};
    tbl[7] = '{24'hABCDEF, 24'h123456, 1'b1, 1'b0, 24'hBE0246, 1'b0, 1'b0};
    tbl[8] = '{24'h000007, 24'h000005, 1'b0, 1'b1, 24'h000002, 1'b1, 1'b0};
    tbl[9] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, 24'hFFFFFF, 1'b1, 1'b0};

    // Reset with in_valid high: nothing may be accepted.
    bus.in_valid = 1'b1; bus.a = 24'h123456; bus.b = 24'h654321;
    bus.cin = 1'b1; bus.sub = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    step(); step();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_overflow", bus.overflow, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin step(); if (bus.out_valid === 1'b1) seen++; end
    check("rst_no_accept", seen, 0);

    // Directed table.
    foreach (tbl[i]) begin
      accept(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
             {tbl[i].sum, tbl[i].cout, tbl[i].ovf}, 1'b1);
      collect($sformatf("tbl%0d", i), 0);
    end

    // Backpressure: hold result for 10 cycles, ignore a stray in_valid.
    accept(24'h123456, 24'h0FEDCB, 1'b0, 1'b0, {24'h222221, 1'b0, 1'b0}, 1'b1);
    wait_valid(seen);
    if (bus.out_valid !== 1'b1) timeout("bp_out_valid");
    else check("bp_latency", seen, L + 2);
    exp = sb[0];
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        bus.in_valid = 1'b1; bus.a = 24'h000111; bus.b = 24'h000222;
      end
      step();
      bus.in_valid = 1'b0;
      check("bp_hold", {bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.overflow},
            {2'b10, exp});
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    void'(sb.pop_front());
    check("bp_release_valid", bus.out_valid, 0);
    check("bp_release_ready", bus.in_ready, 1);
    check("bp_sum_kept", {bus.sum, bus.cout, bus.overflow}, exp);
    seen = 0;
    repeat (12) begin step(); if (bus.out_valid === 1'b1) seen++; end
    check("bp_stray_ignored", seen, 0);

    // Reset mid-RESOLVE discards the operation.
    accept(24'h00FFFF, 24'h000001, 1'b0, 1'b0, '0, 1'b0);
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_outputs", {bus.out_valid, bus.sum, bus.cout, bus.overflow}, 0);
    seen = 0;
    repeat (15) begin step(); if (bus.out_valid === 1'b1) seen++; end
    check("midrst_no_output", seen, 0);

    // Random vectors with random consumer stalls.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      accept(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b1);
      collect("rand", 3);
    end

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
